// File: rtl/sm_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : sm_seq_multiplier
// Brief    : Iterative sign-magnitude multiplier with valid/ready handshakes.
//            Each BUSY cycle multiplies |a| by DIGIT bits of |b| and adds the
//            shifted partial product into the accumulator.
// Options  : SM_MUL_NEG_ZERO_CLR_EN - when defined, a zero product is always
//            reported as +0; otherwise the sign is a^b even for a zero result.
// Revision : 1.0 - initial release
// ============================================================================
module sm_seq_multiplier #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int c_MW    = WIDTH - 1;                  // magnitude width
  localparam int c_NITER = (c_MW + DIGIT - 1) / DIGIT; // iterations per product
  localparam int c_BW    = c_NITER * DIGIT;            // padded |b| width
  localparam int c_ACCW  = 2 * WIDTH - 2;              // product magnitude width
  localparam int c_CW    = (c_NITER > 1) ? $clog2(c_NITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [c_MW-1:0]   r_a;
  logic [c_BW-1:0]   r_b;
  logic              r_sign;
  logic [c_ACCW-1:0] r_acc;
  logic [c_CW-1:0]   r_cnt;
  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic              w_sign;
  logic [c_ACCW-1:0] w_pp;

  // The shifted partial product never exceeds the final magnitude, so
  // computing it modulo 2^c_ACCW loses nothing.
  assign w_pp   = (c_ACCW'(r_a) * c_ACCW'(r_b[DIGIT-1:0])) << (32'(r_cnt) * DIGIT);
  assign w_last = (r_cnt == c_CW'(c_NITER - 1));

`ifdef SM_MUL_NEG_ZERO_CLR_EN
  assign w_sign = r_sign & (r_acc != '0);
`else
  assign w_sign = r_sign;
`endif

  // State register and operand/accumulator datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sign  <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_a    <= a[WIDTH-2:0];
        r_b    <= c_BW'(b[WIDTH-2:0]);
        r_sign <= a[WIDTH-1] ^ b[WIDTH-1];
        r_acc  <= '0;
        r_cnt  <= '0;
      end else if (w_step) begin
        r_acc <= r_acc + w_pp;
        r_b   <= r_b >> DIGIT;
        r_cnt <= r_cnt + c_CW'(1);
      end
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    out          = '0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load       = 1'b1;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        out       = {w_sign, 1'b0, r_acc};
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire
